// File: rtl/fp_align_seq.sv
// Exponent-compare and mantissa-alignment sequencer for the FP32 adder path.
// Optional macro STICKY_EN folds every shifted-out bit into mant_small[0].
module fp_align_seq #(
    parameter int SHIFT_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  ex_big,
    output logic [7:0]  ex_diff,
    output logic        swap,
    output logic [26:0] mant_big,
    output logic [26:0] mant_small,
    output logic        busy
);

    localparam int ALIGN_W = 27;
    localparam logic [4:0] STEP_MAX = 5'(SHIFT_PER_CYCLE);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state;
    logic [4:0]         rem;

    logic [7:0]         exp_a;
    logic [7:0]         exp_b;
    logic               b_is_big;
    logic [7:0]         exp_hi;
    logic [7:0]         exp_lo;
    logic [7:0]         diff_acc;
    logic [4:0]         rem_acc;
    logic [ALIGN_W-1:0] mant_a;
    logic [ALIGN_W-1:0] mant_b;
    logic [4:0]         step_k;
    logic [ALIGN_W-1:0] shifted;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    // Operand decode for the accept edge; ties make B the big operand.
    always_comb begin
        exp_a    = op_a[30:23];
        exp_b    = op_b[30:23];
        b_is_big = !(exp_a > exp_b);
        exp_hi   = b_is_big ? exp_b : exp_a;
        exp_lo   = b_is_big ? exp_a : exp_b;
        diff_acc = exp_hi - exp_lo;
        rem_acc  = (diff_acc > 8'd27) ? 5'd27 : diff_acc[4:0];
        mant_a   = {(exp_a != 8'd0), op_a[22:0], 3'b000};
        mant_b   = {(exp_b != 8'd0), op_b[22:0], 3'b000};
    end

    always_comb begin
        step_k  = (rem > STEP_MAX) ? STEP_MAX : rem;
        shifted = mant_small >> step_k;
`ifdef STICKY_EN
        shifted[0] = shifted[0] | (|(mant_small & ~({ALIGN_W{1'b1}} << step_k)));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rem        <= 5'd0;
            ex_big     <= 8'd0;
            ex_diff    <= 8'd0;
            swap       <= 1'b0;
            mant_big   <= '0;
            mant_small <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        ex_big     <= exp_hi;
                        ex_diff    <= diff_acc;
                        swap       <= b_is_big;
                        mant_big   <= b_is_big ? mant_b : mant_a;
                        mant_small <= b_is_big ? mant_a : mant_b;
                        rem        <= rem_acc;
                        state      <= (rem_acc != 5'd0) ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    mant_small <= shifted;
                    rem        <= rem - step_k;
                    if (rem == step_k) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_align_seq.sv
// Randomised self-checking bench for fp_align_seq against an arithmetic model.
// Define STICKY_EN here as well as for the RTL when building the sticky variant.
module tb_fp_align_seq;

    localparam int SPC = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  ex_big;
    logic [7:0]  ex_diff;
    logic        swap;
    logic [26:0] mant_big;
    logic [26:0] mant_small;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fp_align_seq #(.SHIFT_PER_CYCLE(SPC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ex_big     (ex_big),
        .ex_diff    (ex_diff),
        .swap       (swap),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mant_of(input logic [31:0] x);
        return {37'd0, (x[30:23] != 8'd0), x[22:0], 3'b000};
    endfunction

    // Expected result from plain arithmetic on the IEEE fields.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [7:0] e_big, output logic [7:0] e_diff,
                         output logic e_swap, output logic [26:0] e_mbig,
                         output logic [26:0] e_msmall, output int e_lat);
        int ea, eb, d, r;
        logic [63:0] m, sh, disc;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        e_swap = (ea > eb) ? 1'b0 : 1'b1;
        d = e_swap ? eb - ea : ea - eb;
        e_big  = 8'(e_swap ? eb : ea);
        e_diff = 8'(d);
        e_mbig = 27'(e_swap ? mant_of(b) : mant_of(a));
        m = e_swap ? mant_of(a) : mant_of(b);
        if (d >= 27) begin
            sh = 64'd0;
            disc = m;
        end else begin
            sh = m >> d;
            disc = m & ((64'd1 << d) - 64'd1);
        end
`ifdef STICKY_EN
        if (disc != 64'd0) sh[0] = 1'b1;
`endif
        e_msmall = 27'(sh);
        r = (d > 27) ? 27 : d;
        e_lat = 1 + (r + SPC - 1) / SPC;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [7:0] e_big, e_diff;
        logic e_swap;
        logic [26:0] e_mbig, e_msmall;
        int e_lat, cycles;
        model(a, b, e_big, e_diff, e_swap, e_mbig, e_msmall, e_lat);
        checkOutput("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cycles = 1;
        // Garbage operands while busy must be ignored.
        op_a = $urandom;
        op_b = $urandom;
        while (!out_valid && cycles < 100) begin
            checkOutput("busy_shift", {62'd0, busy, in_ready}, 64'd2);
            @(negedge clk);
            op_a = $urandom;
            op_b = $urandom;
            cycles++;
        end
        checkOutput("latency", 64'(cycles), 64'(e_lat));
        for (int i = 0; i <= hold; i++) begin
            checkOutput("out_valid", {62'd0, out_valid, in_ready}, 64'd2);
            checkOutput("ex_big", {56'd0, ex_big}, {56'd0, e_big});
            checkOutput("ex_diff", {56'd0, ex_diff}, {56'd0, e_diff});
            checkOutput("swap", {63'd0, swap}, {63'd0, e_swap});
            checkOutput("mant_big", {37'd0, mant_big}, {37'd0, e_mbig});
            checkOutput("mant_small", {37'd0, mant_small}, {37'd0, e_msmall});
            if (i < hold) begin
                @(negedge clk);
                op_a = $urandom;
                op_b = $urandom;
            end
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("handover", {61'd0, out_valid, in_ready, busy}, 64'd2);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [7:0] ea;
        int wait_cycles;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_a = 32'd0;
        op_b = 32'd0;
        #12;
        checkOutput("reset_state", {out_valid, busy, in_ready, swap, ex_big, ex_diff, mant_big, mant_small},
                    {1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 27'd0, 27'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(32'h4000_0000, 32'h3F80_0000, 0);
        applyStimulus(32'h3F80_0000, 32'h3F80_0000, 0);
        applyStimulus({1'b0, 8'd150, 23'd0}, {1'b0, 8'd100, 23'h7FFFFF}, 1);
        applyStimulus(32'h4120_0000, 32'h3E00_0001, 5);
        applyStimulus(32'h3F80_0000, 32'h0000_0000, 0);

        // Asynchronous reset in the middle of a diff=20 shift.
        in_valid = 1'b1;
        op_a = {1'b0, 8'd120, 23'h123456};
        op_b = {1'b0, 8'd140, 23'h000001};
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {out_valid, busy, in_ready, swap, ex_big, ex_diff, mant_big, mant_small},
                    {1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 27'd0, 27'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus({1'b0, 8'd120, 23'h123456}, {1'b0, 8'd140, 23'h000001}, 0);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            if (n % 2 == 0) begin
                ea = a[30:23];
                b[30:23] = ea + 8'($urandom_range(0, 30)) - 8'd15;
            end
            applyStimulus(a, b, int'($urandom_range(0, 3)));
        end

        wait_cycles = 0;
        while (!in_ready && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        checkOutput("final_idle", {63'd0, in_ready}, 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
